alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  - Registered output stage directly downstream of the parameterized ALU.
//  - Captures the ALU's combinational outputs (result, carry_out, mult_result) with the opcode that produced them.
//  - Derives status flags and buffers up to two results in a skid FIFO.
//  - Presents buffered results to the consumer over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH   8   ALU operand/result width; must match the ALU instance
//  CNT_WIDTH    8   width of the saturating reserved-opcode error counter
// PORTS
//  clk           in   1              single clock, rising edge
//  rst_n         in   1              asynchronous, active-low reset
//  in_valid      in   1              ALU outputs below are valid this cycle
//  in_ready      out  1              stage can accept; = !full
//  in_opcode     in   5              opcode presented to the ALU ([4:3] unit, [2:0] op)
//  in_result     in   DATA_WIDTH     ALU result
//  in_carry      in   1              ALU carry_out
//  in_mult       in   2*DATA_WIDTH   ALU mult_result
//  out_valid     out  1              head entry valid
//  out_ready     in   1              consumer accepts head entry
//  out_result    out  DATA_WIDTH     head result
//  out_mult      out  2*DATA_WIDTH   head mult_result
//  out_flags     out  4              {err, carry, neg, zero} of head entry
//  err_count     out  CNT_WIDTH      count of accepted reserved-unit opcodes
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset values: out_valid=0, in_ready=1, out_result/out_mult/out_flags=0, err_count=0, FIFO empty.
//  - Reset asserted mid-transfer discards all entries immediately.
//  - Accept when in_valid && in_ready; pop when out_valid && out_ready.
//  - Storage: 2-entry FIFO; occupancy 0/1/2.
//    - Latency: an entry accepted on edge N is visible at outputs after edge N (out_valid=1 from cycle N+1).
//    - No combinational in->out path.
//  - in_ready depends only on registered occupancy, never on out_ready.
//    - Full (2): in_ready=0; a pop that cycle frees space on the next cycle only.
//  - Simultaneous push+pop at occupancy 1: head advances to the new entry; occupancy stays 1.
//  - Simultaneous push+pop at occupancy 0: impossible (out_valid=0); push only.
//  - Holding rule: while out_valid && !out_ready, all out_* stay stable.
//  - Flags, computed at capture from in_* and stored per entry:
//    - zero  = (in_result == 0)
//    - neg   = in_result[DATA_WIDTH-1]
//    - carry = in_carry
//    - err   = (in_opcode[4:3] == 2'b11)
//  - Reserved unit handling:
//    - When err=1, the stored result and mult are forced to 0, so zero=1 and neg=0.
//    - err_count increments on each accepted err entry and saturates at 2^CNT_WIDTH-1 (no wrap).
//  - Inputs presented while in_ready=0 are ignored; the upstream holds them.
//  - out_* when out_valid=0: hold the last popped value (registered, no X).
// STRUCTURE
//  - Shared package alu_pkg:
//    - unit-select constants UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_SHIFT=2'b10, UNIT_RSVD=2'b11
//    - flag bit indices FLG_ZERO=0, FLG_NEG=1, FLG_CARRY=2, FLG_ERR=3
//  - The ALU top is to adopt alu_pkg as well.
//  - Sub-module alu_skid_fifo: generic 2-entry valid/ready FIFO, payload width parameter.
//  - alu_result_stage = flag logic + err counter + one alu_skid_fifo instance.
// TESTING
//  - Reset: rst_n=0 mid-stream with 2 entries held -> out_valid=0, in_ready=1, err_count=0 asynchronously, before the next edge.
//  - Single pass, out_ready=1: opcode=5'b00000, result=8'h00, carry=1 -> next cycle out_valid=1, out_flags=4'b0101.
//  - Backpressure: out_ready=0, push 8'h80, 8'h05, 8'h11 on consecutive cycles:
//    - 8'h80 and 8'h05 accepted; in_ready=0 after the 2nd push; 8'h11 not accepted.
//    - out_result holds 8'h80 with flags 4'b0010.
//  - Drain order: raise out_ready -> 8'h80 then 8'h05 pop on consecutive cycles; in_ready returns to 1 one cycle after the first pop.
//  - Reserved opcode: opcode=5'b11010, result=8'hFF, mult=16'h1234 -> out_result=0, out_mult=0, out_flags=4'b1001, err_count=1.
//  - Saturation: CNT_WIDTH=2, seven accepted reserved opcodes -> err_count=3.
//  - Throughput: continuous in_valid and out_ready=1 -> one result per cycle with occupancy held at 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit-select encodings of opcode[4:3] and status flag bit positions.
package alu_pkg;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_SHIFT = 2'b10;
   localparam logic [1:0] UNIT_RSVD  = 2'b11;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_NEG   = 1;
   localparam int FLG_CARRY = 2;
   localparam int FLG_ERR   = 3;
   localparam int FLAG_W    = 4;

endpackage

// File: rtl/alu_skid_fifo.sv
// Generic 2-entry valid/ready FIFO with a registered head; the head keeps the last
// popped payload while empty. Input ready depends only on the registered occupancy.
module alu_skid_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_data,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_out_data
);

   logic [1:0]   r_count;
   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic         w_push;
   logic         w_pop;

   assign o_in_ready  = (r_count != 2'd2);
   assign o_out_valid = (r_count != 2'd0);
   assign o_out_data  = r_head;
   assign w_push      = i_in_valid && o_in_ready;
   assign w_pop       = o_out_valid && i_out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         // The head loads new data when it is empty or being vacated with nothing behind it.
         if (w_pop && (r_count == 2'd2))
            r_head <= r_tail;
         else if (w_push && ((r_count == 2'd0) || w_pop))
            r_head <= i_in_data;
         if (w_push && (r_count == 2'd1) && !w_pop)
            r_tail <= i_in_data;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: derives status flags, counts reserved-unit
// opcodes (saturating) and buffers results in a 2-entry FIFO toward the consumer.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4:0]              in_opcode,
   input  logic [DATA_WIDTH-1:0]   in_result,
   input  logic                    in_carry,
   input  logic [2*DATA_WIDTH-1:0] in_mult,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_result,
   output logic [2*DATA_WIDTH-1:0] out_mult,
   output logic [FLAG_W-1:0]       out_flags,
   output logic [CNT_WIDTH-1:0]    err_count
);

   localparam int PW = 3*DATA_WIDTH + FLAG_W;

   logic                    w_err;
   logic [DATA_WIDTH-1:0]   w_result;
   logic [2*DATA_WIDTH-1:0] w_mult;
   logic [FLAG_W-1:0]       w_flags;
   logic [PW-1:0]           w_in_payload;
   logic [PW-1:0]           w_out_payload;
   logic                    w_accept;
   logic                    w_unused_op;
   logic [CNT_WIDTH-1:0]    r_err_count;

   // The op field only matters to the ALU itself; only the unit field is decoded here.
   assign w_unused_op = &{1'b0, in_opcode[2:0]};

   assign w_err    = (in_opcode[4:3] == UNIT_RSVD);
   assign w_result = w_err ? '0 : in_result;
   assign w_mult   = w_err ? '0 : in_mult;

   always_comb begin
      w_flags            = '0;
      w_flags[FLG_ZERO]  = (w_result == '0);
      w_flags[FLG_NEG]   = w_result[DATA_WIDTH-1];
      w_flags[FLG_CARRY] = in_carry;
      w_flags[FLG_ERR]   = w_err;
   end

   assign w_in_payload = {w_mult, w_result, w_flags};
   assign w_accept     = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_count <= '0;
      else if (w_accept && w_err && (r_err_count != {CNT_WIDTH{1'b1}}))
         r_err_count <= r_err_count + 1'b1;
   end

   assign err_count = r_err_count;

   alu_skid_fifo #(
      .W (PW)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (w_in_payload),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (w_out_payload)
   );

   assign out_mult   = w_out_payload[PW-1 -: 2*DATA_WIDTH];
   assign out_result = w_out_payload[FLAG_W +: DATA_WIDTH];
   assign out_flags  = w_out_payload[FLAG_W-1:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  in_opcode = '0;
   logic [7:0]  in_result = '0;
   logic        in_carry = 1'b0;
   logic [15:0] in_mult = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid;
   logic [7:0]  out_result;
   logic [15:0] out_mult;
   logic [3:0]  out_flags;
   logic [7:0]  err_count;

   logic        s_in_ready, s_out_valid;
   logic [7:0]  s_out_result;
   logic [15:0] s_out_mult;
   logic [3:0]  s_out_flags;
   logic [1:0]  s_err_count;

   always #5 clk = ~clk;

   alu_result_stage #(.DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_result(in_result), .in_carry(in_carry), .in_mult(in_mult),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_mult(out_mult), .out_flags(out_flags), .err_count(err_count));

   alu_result_stage #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_opcode(in_opcode), .in_result(in_result), .in_carry(in_carry), .in_mult(in_mult),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
      .out_mult(s_out_mult), .out_flags(s_out_flags), .err_count(s_err_count));

   typedef struct packed {
      logic [7:0]  res;
      logic [15:0] mult;
      logic [3:0]  flags;
   } ent_t;

   ent_t q[$];
   ent_t last_out = '0;
   int   n_err = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic ent_t make_ent(input logic [4:0] op, input logic [7:0] r,
                                     input logic c, input logic [15:0] m);
      ent_t e;
      logic err;
      err     = (op[4:3] == 2'b11);
      e.res   = err ? 8'h00 : r;
      e.mult  = err ? 16'h0000 : m;
      e.flags = {err, c, e.res[7], (e.res == 8'h00)};
      return e;
   endfunction

   task automatic compare();
      ent_t e;
      int   exp8, exp2;
      e    = (q.size() > 0) ? q[0] : last_out;
      exp8 = (n_err > 255) ? 255 : n_err;
      exp2 = (n_err > 3) ? 3 : n_err;
      chk("out_valid",    64'(out_valid),  64'(q.size() > 0));
      chk("in_ready",     64'(in_ready),   64'(q.size() < 2));
      chk("out_result",   64'(out_result), 64'(e.res));
      chk("out_mult",     64'(out_mult),   64'(e.mult));
      chk("out_flags",    64'(out_flags),  64'(e.flags));
      chk("err_count",    64'(err_count),  64'(exp8));
      chk("sat_valid",    64'(s_out_valid), 64'(q.size() > 0));
      chk("sat_ready",    64'(s_in_ready),  64'(q.size() < 2));
      chk("sat_result",   64'(s_out_result), 64'(e.res));
      chk("sat_mult",     64'(s_out_mult),  64'(e.mult));
      chk("sat_flags",    64'(s_out_flags), 64'(e.flags));
      chk("sat_err_count", 64'(s_err_count), 64'(exp2));
   endtask

   // Drive one cycle's inputs (called just after a falling edge), advance the model,
   // then compare after the next rising edge.
   task automatic step(input logic v, input logic [4:0] op, input logic [7:0] r,
                       input logic c, input logic [15:0] m, input logic rdy);
      logic acc, pop;
      in_valid  = v;
      in_opcode = op;
      in_result = r;
      in_carry  = c;
      in_mult   = m;
      out_ready = rdy;
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && rdy;
      if (pop) last_out = q.pop_front();
      if (acc) begin
         q.push_back(make_ent(op, r, c, m));
         if (op[4:3] == 2'b11) n_err++;
      end
      @(posedge clk);
      @(negedge clk);
      compare();
      $display("cyc v=%0b op=%02h r=%02h c=%0b rdy=%0b -> ov=%0b ir=%0b res=%02h fl=%01h ec=%0d",
               v, op, r, c, rdy, out_valid, in_ready, out_result, out_flags, err_count);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 5'd0, 8'd0, 1'b0, 16'd0, rdy);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      compare();
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready",  64'(in_ready),  64'd1);
      chk("reset_err_count", 64'(err_count), 64'd0);
      rst_n = 1'b1;
      idle(1'b1);

      // Single pass: zero result with carry
      step(1'b1, 5'b00000, 8'h00, 1'b1, 16'h0000, 1'b1);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_flags", 64'(out_flags), 64'h5);
      idle(1'b1);

      // Backpressure
      step(1'b1, 5'b00001, 8'h80, 1'b0, 16'h0100, 1'b0);
      step(1'b1, 5'b00010, 8'h05, 1'b0, 16'h0200, 1'b0);
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      step(1'b1, 5'b00011, 8'h11, 1'b0, 16'h0300, 1'b0);
      step(1'b1, 5'b00011, 8'h11, 1'b0, 16'h0300, 1'b0);
      chk("bp_hold_result", 64'(out_result), 64'h80);
      chk("bp_hold_flags",  64'(out_flags),  64'h2);

      // Drain
      idle(1'b1);
      chk("drain_first",  64'(out_result), 64'h05);
      chk("drain_ready",  64'(in_ready),   64'd1);
      idle(1'b1);
      chk("drain_empty",  64'(out_valid),  64'd0);
      chk("drain_holdval", 64'(out_result), 64'h05);

      // Reserved opcode
      step(1'b1, 5'b11010, 8'hFF, 1'b0, 16'h1234, 1'b1);
      chk("rsvd_result", 64'(out_result), 64'h00);
      chk("rsvd_mult",   64'(out_mult),   64'h0000);
      chk("rsvd_flags",  64'(out_flags),  64'h9);
      chk("rsvd_count",  64'(err_count),  64'd1);
      idle(1'b1);

      // Asynchronous reset with two entries held
      step(1'b1, 5'b11000, 8'h33, 1'b1, 16'h5555, 1'b0);
      step(1'b1, 5'b01001, 8'h42, 1'b0, 16'h6666, 1'b0);
      chk("prereset_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid),  64'd0);
      chk("arst_in_ready",  64'(in_ready),   64'd1);
      chk("arst_err_count", 64'(err_count),  64'd0);
      chk("arst_result",    64'(out_result), 64'd0);
      chk("arst_flags",     64'(out_flags),  64'd0);
      q.delete();
      last_out = '0;
      n_err = 0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      compare();

      // Saturation of the 2-bit counter
      for (int i = 0; i < 7; i++)
         step(1'b1, {2'b11, 3'($urandom_range(0, 7))}, 8'($urandom), 1'b0, 16'($urandom), 1'b1);
      idle(1'b1);
      chk("sat_count3", 64'(s_err_count), 64'd3);
      chk("count7",     64'(err_count),   64'd7);

      // Throughput: one result per cycle, occupancy held at one
      for (int i = 0; i < 20; i++) begin
         step(1'b1, {2'($urandom_range(0, 2)), 3'($urandom_range(0, 7))}, 8'($urandom),
              1'($urandom), 16'($urandom), 1'b1);
         chk("thru_in_ready", 64'(in_ready), 64'd1);
      end
      idle(1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 3) != 0), 5'($urandom), 8'($urandom), 1'($urandom),
              16'($urandom), 1'($urandom_range(0, 2) != 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
